trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_pkg.sv | 43 ++++
 rtl/trap_ctrl_irq_prio.sv | 31 +++
 rtl/trap_ctrl.sv | 145 ++++++++++++++
 tb/tb_trap_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg
// Shared constants for the machine-mode trap controller: interrupt cause
// codes, the CSR indices for mepc/mcause, mtvec mode encodings, the FSM
// state type, and a helper that computes the trap vector target.
// No ports. Import with: import trap_ctrl_pkg::*;

package trap_ctrl_pkg;

    // Machine-level interrupt cause codes, which are also the mie/mip bit positions.
    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MSI = 4'd3;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    // CSR addresses that software may write through csr_wen.
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    // mtvec mode field. Only VECTORED changes the target. Every other
    // encoding, including the reserved ones, behaves as direct mode.
    localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
    localparam logic [1:0] MTVEC_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_RET  = 2'd2,
        ST_WAIT = 2'd3
    } trap_state_t;

    // The trap target is the aligned mtvec base. Vectored mode adds code*4
    // for interrupts only. The 32-bit sum wraps around naturally.
    function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                                input logic        is_irq,
                                                input logic [3:0]  code);
        logic [31:0] base;
        base = {mtvec[31:2], 2'b00};
        if (is_irq && (mtvec[1:0] == MTVEC_VECTORED))
            trap_target = base + {26'b0, code, 2'b00};
        else
            trap_target = base;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// irq_prio
// Fixed-priority encoder for the three machine interrupt sources.
// Priority order: MEI > MSI > MTI.
// Ports:
//   req   in  3 : candidate requests, [2]=MEI, [1]=MSI, [0]=MTI
//   valid out 1 : at least one request is active
//   code  out 4 : cause code of the winning request (0 when none)

module irq_prio
    import trap_ctrl_pkg::*;
(
    input  logic [2:0] req,
    output logic       valid,
    output logic [3:0] code
);

    // The highest-priority active request wins.
    always_comb begin
        valid = 1'b1;
        code  = 4'd0;
        if (req[2])
            code = CAUSE_MEI;
        else if (req[1])
            code = CAUSE_MSI;
        else if (req[0])
            code = CAUSE_MTI;
        else
            valid = 1'b0;
    end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl
// Machine-mode trap and mret sequencer. In IDLE it chooses one event: an
// exception first, then an interrupt, then mret. It captures mepc/mcause,
// pulses the CSR file, and asks the pipeline to flush and redirect until
// the pipeline acknowledges.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   mstatus_mie, mie_r, mip_r   : interrupt enable/pending state (bits 11/7/3)
//   mtvec_r                     : trap vector base and mode
//   commit_valid, commit_pc     : retiring instruction and next PC
//   exc_valid, exc_code, exc_pc : synchronous exception at commit
//   mret_valid                  : mret retires
//   flush_ack                   : pipeline has flushed and redirected
//   trap_ena, mret_ena          : one-cycle pulses to the CSR file
//   flush_req, flush_pc         : flush/redirect request and target
//   mepc_r, mcause_r            : mepc/mcause CSR values
//   csr_wen, csr_idx, csr_wdat  : software writes to mepc/mcause

module trap_ctrl
    import trap_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mstatus_mie,
    input  logic [31:0] mie_r,
    input  logic [31:0] mip_r,
    input  logic [31:0] mtvec_r,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        exc_valid,
    input  logic [3:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        mret_valid,
    input  logic        flush_ack,
    output logic        trap_ena,
    output logic        mret_ena,
    output logic        flush_req,
    output logic [31:0] flush_pc,
    output logic [31:0] mepc_r,
    output logic [31:0] mcause_r,
    input  logic        csr_wen,
    input  logic [11:0] csr_idx,
    input  logic [31:0] csr_wdat
);

    trap_state_t state;
    logic [31:0] tgt_pc;
    logic [2:0]  irq_req;
    logic        irq_valid;
    logic [3:0]  irq_code;

    // Only bits 11, 7 and 3 of mie/mip take part in interrupt selection.
    // Signals whose names contain "unused" are not reported as unused by lint.
    logic unused_bits;
    assign unused_bits = ^{mie_r[31:12], mie_r[10:8], mie_r[6:4], mie_r[2:0],
                           mip_r[31:12], mip_r[10:8], mip_r[6:4], mip_r[2:0]};

    // An interrupt is a candidate only when it is enabled globally and per
    // source, and only at an instruction boundary.
    always_comb begin
        irq_req[2] = mstatus_mie & mie_r[11] & mip_r[11] & commit_valid;
        irq_req[1] = mstatus_mie & mie_r[3]  & mip_r[3]  & commit_valid;
        irq_req[0] = mstatus_mie & mie_r[7]  & mip_r[7]  & commit_valid;
    end

    irq_prio u_irq_prio (
        .req   (irq_req),
        .valid (irq_valid),
        .code  (irq_code)
    );

    // Main sequencer. Events are examined only in IDLE, so anything that
    // arrives during TAKE, RET or WAIT is dropped. The redirect target goes
    // into tgt_pc on entry and stays fixed until WAIT exits. That keeps
    // flush_pc stable even if mtvec or mepc change while the flush is pending.
    // Software CSR writes are accepted only in IDLE when no trap is captured
    // in the same cycle, so a trap capture always takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            trap_ena  <= 1'b0;
            mret_ena  <= 1'b0;
            flush_req <= 1'b0;
            tgt_pc    <= 32'h0;
            mepc_r    <= 32'h0;
            mcause_r  <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (exc_valid) begin
                        state     <= ST_TAKE;
                        trap_ena  <= 1'b1;
                        flush_req <= 1'b1;
                        mepc_r    <= {exc_pc[31:2], 2'b00};
                        mcause_r  <= {28'b0, exc_code};
                        tgt_pc    <= trap_target(mtvec_r, 1'b0, exc_code);
                    end else if (irq_valid) begin
                        state     <= ST_TAKE;
                        trap_ena  <= 1'b1;
                        flush_req <= 1'b1;
                        mepc_r    <= {commit_pc[31:2], 2'b00};
                        mcause_r  <= {1'b1, 27'b0, irq_code};
                        tgt_pc    <= trap_target(mtvec_r, 1'b1, irq_code);
                    end else begin
                        if (mret_valid) begin
                            state     <= ST_RET;
                            mret_ena  <= 1'b1;
                            flush_req <= 1'b1;
                            tgt_pc    <= mepc_r;
                        end
                        if (csr_wen && (csr_idx == CSR_MEPC))
                            mepc_r <= {csr_wdat[31:2], 2'b00};
                        if (csr_wen && (csr_idx == CSR_MCAUSE))
                            mcause_r <= csr_wdat;
                    end
                end
                ST_TAKE: begin
                    state    <= ST_WAIT;
                    trap_ena <= 1'b0;
                end
                ST_RET: begin
                    state    <= ST_WAIT;
                    mret_ena <= 1'b0;
                end
                ST_WAIT: begin
                    if (flush_ack) begin
                        state     <= ST_IDLE;
                        flush_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    trap_ena  <= 1'b0;
                    mret_ena  <= 1'b0;
                    flush_req <= 1'b0;
                end
            endcase
        end
    end

    // Outside IDLE the redirect target comes from the captured register.
    // In IDLE the output is held at zero.
    assign flush_pc = (state == ST_IDLE) ? 32'h0 : tgt_pc;

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl
// Scoreboard bench for trap_ctrl. Stimulus pushes the expected
// mepc/mcause/flush_pc for every trap or mret it causes. A monitor pops one
// entry on each trap_ena/mret_ena pulse and flags any pulse it did not expect.

module tb_trap_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mstatus_mie;
    logic [31:0] mie_r;
    logic [31:0] mip_r;
    logic [31:0] mtvec_r;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        exc_valid;
    logic [3:0]  exc_code;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic        flush_ack;
    logic        trap_ena;
    logic        mret_ena;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [31:0] mepc_r;
    logic [31:0] mcause_r;
    logic        csr_wen;
    logic [11:0] csr_idx;
    logic [31:0] csr_wdat;

    typedef struct {
        logic        is_mret;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] fpc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    trap_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mstatus_mie  (mstatus_mie),
        .mie_r        (mie_r),
        .mip_r        (mip_r),
        .mtvec_r      (mtvec_r),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_pc       (exc_pc),
        .mret_valid   (mret_valid),
        .flush_ack    (flush_ack),
        .trap_ena     (trap_ena),
        .mret_ena     (mret_ena),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .mepc_r       (mepc_r),
        .mcause_r     (mcause_r),
        .csr_wen      (csr_wen),
        .csr_idx      (csr_idx),
        .csr_wdat     (csr_wdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and count the result.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic is_mret, input logic [31:0] mepc,
                           input logic [31:0] mcause, input logic [31:0] fpc);
        exp_t e;
        e.is_mret = is_mret;
        e.mepc    = mepc;
        e.mcause  = mcause;
        e.fpc     = fpc;
        exp_q.push_back(e);
    endtask

    // Drive a set of event inputs for exactly one clock, then clear them.
    // The task returns just after the edge that sampled the inputs.
    task automatic applyStimulus(input logic e_v, input logic [3:0] e_code, input logic [31:0] e_pc,
                                 input logic m_v, input logic c_v, input logic [31:0] c_pc,
                                 input logic w_v, input logic [11:0] w_idx, input logic [31:0] w_dat);
        @(posedge clk); #1;
        exc_valid    = e_v;
        exc_code     = e_code;
        exc_pc       = e_pc;
        mret_valid   = m_v;
        commit_valid = c_v;
        commit_pc    = c_pc;
        csr_wen      = w_v;
        csr_idx      = w_idx;
        csr_wdat     = w_dat;
        @(posedge clk); #1;
        exc_valid    = 1'b0;
        mret_valid   = 1'b0;
        commit_valid = 1'b0;
        csr_wen      = 1'b0;
    endtask

    // Follow a trap from TAKE through WAIT and back to IDLE with an immediate ack.
    task automatic finishFlow(input logic [31:0] fpc);
        @(negedge clk);
        @(negedge clk);
        checkOutput("pulse_one_cycle", {31'b0, trap_ena | mret_ena}, 32'h0);
        checkOutput("flush_req_wait", {31'b0, flush_req}, 32'h1);
        checkOutput("flush_pc_hold", flush_pc, fpc);
        @(posedge clk); #1;
        flush_ack = 1'b1;
        @(posedge clk); #1;
        flush_ack = 1'b0;
        @(negedge clk);
        checkOutput("flush_req_release", {31'b0, flush_req}, 32'h0);
    endtask

    // On each trap/mret pulse, take the oldest expected entry and compare.
    always @(negedge clk) begin
        if (rst_n && (trap_ena || mret_ena)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: trap_ena=%0b mret_ena=%0b, expected none",
                         trap_ena, mret_ena);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("pulse_kind", {30'b0, mret_ena, trap_ena}, e.is_mret ? 32'h2 : 32'h1);
                checkOutput("mepc", mepc_r, e.mepc);
                checkOutput("mcause", mcause_r, e.mcause);
                checkOutput("flush_pc", flush_pc, e.fpc);
                checkOutput("flush_req_pulse", {31'b0, flush_req}, 32'h1);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        mstatus_mie = 1'b1; mie_r = 32'h0; mip_r = 32'h0; mtvec_r = 32'h100;
        commit_valid = 1'b0; commit_pc = 32'h0;
        exc_valid = 1'b0; exc_code = 4'h0; exc_pc = 32'h0;
        mret_valid = 1'b0; flush_ack = 1'b0;
        csr_wen = 1'b0; csr_idx = 12'h0; csr_wdat = 32'h0;

        // Check the outputs while reset is held.
        #12;
        checkOutput("rst_trap_ena", {31'b0, trap_ena}, 32'h0);
        checkOutput("rst_flush_req", {31'b0, flush_req}, 32'h0);
        checkOutput("rst_mepc", mepc_r, 32'h0);
        checkOutput("rst_mcause", mcause_r, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        // Direct mode, MEI and MTI both pending: MEI wins.
        mtvec_r = 32'h100; mie_r = 32'h880; mip_r = 32'h880;
        pushExp(1'b0, 32'h2004, 32'h8000000B, 32'h100);
        applyStimulus(0, 0, 0, 0, 1, 32'h2004, 0, 0, 0);
        finishFlow(32'h100);

        // Vectored mode with MTI only: 0x100 + 7*4.
        mtvec_r = 32'h101; mie_r = 32'h80; mip_r = 32'h80;
        pushExp(1'b0, 32'h5008, 32'h80000007, 32'h11C);
        applyStimulus(0, 0, 0, 0, 1, 32'h5008, 0, 0, 0);
        finishFlow(32'h11C);

        // Vectored mode with an exception: no offset is added.
        pushExp(1'b0, 32'h6008, 32'h2, 32'h100);
        applyStimulus(1, 4'd2, 32'h600A, 0, 0, 0, 0, 0, 0);
        finishFlow(32'h100);

        // MSI outranks MTI: 0x100 + 3*4.
        mie_r = 32'h888; mip_r = 32'h088;
        pushExp(1'b0, 32'h700C, 32'h80000003, 32'h10C);
        applyStimulus(0, 0, 0, 0, 1, 32'h700C, 0, 0, 0);
        finishFlow(32'h10C);

        // Mode 2'b11 behaves as direct.
        mtvec_r = 32'h203; mip_r = 32'h800;
        pushExp(1'b0, 32'h7010, 32'h8000000B, 32'h200);
        applyStimulus(0, 0, 0, 0, 1, 32'h7010, 0, 0, 0);
        finishFlow(32'h200);

        // Vectored target wraps: 0xFFFFFFF0 + 44 = 0x1C.
        mtvec_r = 32'hFFFF_FFF1;
        pushExp(1'b0, 32'h7014, 32'h8000000B, 32'h1C);
        applyStimulus(0, 0, 0, 0, 1, 32'h7014, 0, 0, 0);
        finishFlow(32'h1C);

        // An exception and MEI in the same cycle: the exception wins.
        mtvec_r = 32'h100;
        pushExp(1'b0, 32'h7000, 32'h5, 32'h100);
        applyStimulus(1, 4'd5, 32'h7000, 0, 1, 32'h7004, 0, 0, 0);
        finishFlow(32'h100);

        // Software writes mepc, then mret with a delayed ack. Requests issued
        // during WAIT must be ignored.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12'h341, 32'h3000);
        @(negedge clk);
        checkOutput("csr_mepc_idle", mepc_r, 32'h3000);
        pushExp(1'b1, 32'h3000, 32'h5, 32'h3000);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (flush_req) cnt++;
            if (k == 1) begin
                exc_valid = 1'b1; exc_code = 4'd9; exc_pc = 32'hA000;
                mret_valid = 1'b1; commit_valid = 1'b1; commit_pc = 32'hA004;
                csr_wen = 1'b1; csr_idx = 12'h341; csr_wdat = 32'h4003;
            end
            if (k == 2) checkOutput("mret_flush_pc_hold", flush_pc, 32'h3000);
            if (k == 3) begin
                exc_valid = 1'b0; mret_valid = 1'b0; commit_valid = 1'b0; csr_wen = 1'b0;
            end
            if (k == 5) flush_ack = 1'b1;
            if (k == 6) flush_ack = 1'b0;
        end
        checkOutput("flush_req_cycles", cnt, 32'd6);
        checkOutput("csr_mepc_wait_dropped", mepc_r, 32'h3000);

        // CSR writes in IDLE.
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12'h341, 32'h4003);
        @(negedge clk);
        checkOutput("csr_mepc_align", mepc_r, 32'h4000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 12'h342, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("csr_mcause", mcause_r, 32'hDEADBEEF);

        // A trap capture takes precedence over a simultaneous CSR write.
        pushExp(1'b0, 32'h8004, 32'h4, 32'h100);
        applyStimulus(1, 4'd4, 32'h8004, 0, 0, 0, 1, 12'h341, 32'h9998);
        finishFlow(32'h100);

        // Reset during WAIT abandons the trap.
        pushExp(1'b0, 32'h9000, 32'h1, 32'h100);
        applyStimulus(1, 4'd1, 32'h9000, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rstw_trap_ena", {31'b0, trap_ena}, 32'h0);
        checkOutput("rstw_mret_ena", {31'b0, mret_ena}, 32'h0);
        checkOutput("rstw_flush_req", {31'b0, flush_req}, 32'h0);
        checkOutput("rstw_flush_pc", flush_pc, 32'h0);
        checkOutput("rstw_mepc", mepc_r, 32'h0);
        checkOutput("rstw_mcause", mcause_r, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (trap_ena || flush_req) cnt++;
        end
        checkOutput("post_reset_quiet", cnt, 32'd0);

        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
